// File: rtl/crono_ctrl_multi_pkg.sv
`default_nettype none
// ============================================================================
// Package  : crono_pkg
// Brief    : Shared types and command codes for the multi-channel
//            chronometer controller.
// Revision : 1.0 - initial release
// ============================================================================
package crono_pkg;

    // Per-channel sequence states
    typedef enum logic [2:0] {
        CH_IDLE      = 3'd0,
        CH_REQ_START = 3'd1,
        CH_START_WR  = 3'd2,
        CH_RUN       = 3'd3,
        CH_REQ_STOP  = 3'd4,
        CH_STOP_WR   = 3'd5,
        CH_RING      = 3'd6
    } chan_state_e;

    // Shared command-writer states
    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_WRITE = 2'd1,
        WR_GAP   = 2'd2
    } wr_state_e;

    localparam logic [2:0] CMD_START = 3'b101;
    localparam logic [2:0] CMD_STOP  = 3'b110;
    localparam logic [2:0] CMD_NONE  = 3'b000;

    // RTC address of a channel; wraps modulo 256
    function automatic logic [7:0] chan_dir(input logic [7:0] base, input int c);
        return base + 8'(c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/crono_ctrl_multi_if.sv
`default_nettype none
// ============================================================================
// Interface: crono_ctrl_multi_if
// Brief    : Button/readback inputs and RTC command bus of the
//            multi-channel chronometer controller.
// Revision : 1.0 - initial release
// ============================================================================
interface crono_ctrl_multi_if #(
    parameter int NCH = 2
);
    logic [NCH-1:0] push;
    logic [NCH-1:0] crono_end;
    logic           WR_inistop;
    logic [2:0]     inistop;
    logic [7:0]     dir;
    logic [NCH-1:0] ring;
    logic [NCH-1:0] busy;

    // Controller side
    modport master (
        input  push, crono_end,
        output WR_inistop, inistop, dir, ring, busy
    );

    // Environment side (buttons, RTC bus, alarm)
    modport slave (
        output push, crono_end,
        input  WR_inistop, inistop, dir, ring, busy
    );
endinterface
`default_nettype wire

// File: rtl/crono_ctrl_multi_chan.sv
`default_nettype none
// ============================================================================
// Module   : crono_chan
// Brief    : One chronometer channel: push edge detector, start/run/stop/
//            ring sequence FSM and optional ring auto-silence timer.
// Revision : 1.0 - initial release
// ============================================================================
module crono_chan
    import crono_pkg::*;
#(
    parameter int RING_TIMEOUT = 0
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_push,
    input  wire logic i_crono_end,
    input  wire logic i_grant,
    input  wire logic i_done,
    output logic      o_req,
    output logic      o_is_stop,
    output logic      o_ring,
    output logic      o_busy
);

    localparam int c_RCNT_W = (RING_TIMEOUT > 0) ? $clog2(RING_TIMEOUT + 1) : 1;

    chan_state_e         r_state;
    chan_state_e         w_next;
    logic                r_push_q;
    logic                r_abort;
    logic                w_abort_next;
    logic [c_RCNT_W-1:0] r_ring_cnt;
    logic                w_push_edge;
    logic                w_ring_expired;

    assign w_push_edge    = i_push & ~r_push_q;
    assign w_ring_expired = (RING_TIMEOUT != 0) && (int'(r_ring_cnt) == RING_TIMEOUT - 1);

    assign o_req     = (r_state == CH_REQ_START) || (r_state == CH_REQ_STOP);
    assign o_is_stop = (r_state == CH_REQ_STOP);

    // Next-state and abort-flag logic; crono_end outranks a push in RUN
    always_comb begin
        w_next       = r_state;
        w_abort_next = r_abort;
        case (r_state)
            CH_IDLE:      if (w_push_edge) w_next = CH_REQ_START;
            CH_REQ_START: if (i_grant) w_next = CH_START_WR;
            CH_START_WR:  if (i_done) w_next = CH_RUN;
            CH_RUN: begin
                if (i_crono_end) begin
                    w_next       = CH_REQ_STOP;
                    w_abort_next = 1'b0;
                end else if (w_push_edge) begin
                    w_next       = CH_REQ_STOP;
                    w_abort_next = 1'b1;
                end
            end
            CH_REQ_STOP:  if (i_grant) w_next = CH_STOP_WR;
            CH_STOP_WR:   if (i_done) w_next = r_abort ? CH_IDLE : CH_RING;
            CH_RING:      if (w_push_edge || w_ring_expired) w_next = CH_IDLE;
            default:      w_next = CH_IDLE;
        endcase
    end

    // State, edge-detector history, ring timer and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= CH_IDLE;
            r_push_q   <= 1'b0;
            r_abort    <= 1'b0;
            r_ring_cnt <= '0;
            o_ring     <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_push_q <= i_push;
            r_abort  <= w_abort_next;
            o_ring   <= (w_next == CH_RING);
            o_busy   <= (w_next != CH_IDLE);
            // Counter is held at zero outside RING so each ring starts fresh
            if (r_state != CH_RING)
                r_ring_cnt <= '0;
            else if (RING_TIMEOUT != 0)
                r_ring_cnt <= r_ring_cnt + c_RCNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/crono_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module   : crono_ctrl_multi
// Brief    : NCH chronometer channels sharing one RTC command writer,
//            granted round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module crono_ctrl_multi
    import crono_pkg::*;
#(
    parameter int         NCH          = 2,
    parameter int         HOLD_CYCLES  = 511,
    parameter logic [7:0] DIR_BASE     = 8'h00,
    parameter int         RING_TIMEOUT = 0
) (
    input wire logic          clk,
    input wire logic          reset,
    crono_ctrl_multi_if.master bus
);

    localparam int c_HCNT_W = $clog2(HOLD_CYCLES + 1);
    localparam int c_PTR_W  = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0]     w_req;
    logic [NCH-1:0]     w_is_stop;
    logic [NCH-1:0]     w_grant;
    logic [NCH-1:0]     w_done;
    logic [NCH-1:0]     w_ring;
    logic [NCH-1:0]     w_busy;

    wr_state_e          r_wstate;
    logic [c_HCNT_W-1:0] r_hold_cnt;
    logic [c_PTR_W-1:0] r_ptr;
    logic [c_PTR_W-1:0] r_owner;
    logic               r_wr;
    logic [2:0]         r_inistop;
    logic [7:0]         r_dir;

    logic               w_wr_free;
    logic               w_gnt_any;
    logic               w_gnt_valid;
    logic [c_PTR_W-1:0] w_gnt_idx;
    logic               w_gnt_stop;
    logic [c_PTR_W-1:0] w_ptr_next;
    logic               w_last;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            crono_chan #(
                .RING_TIMEOUT (RING_TIMEOUT)
            ) u_chan (
                .clk         (clk),
                .reset       (reset),
                .i_push      (bus.push[gi]),
                .i_crono_end (bus.crono_end[gi]),
                .i_grant     (w_grant[gi]),
                .i_done      (w_done[gi]),
                .o_req       (w_req[gi]),
                .o_is_stop   (w_is_stop[gi]),
                .o_ring      (w_ring[gi]),
                .o_busy      (w_busy[gi])
            );
        end
    endgenerate

    // The GAP cycle is already low on the bus, so a new grant may be issued
    // during it; this keeps back-to-back commands exactly one cycle apart.
    assign w_wr_free   = (r_wstate == WR_IDLE) || (r_wstate == WR_GAP);
    assign w_gnt_valid = w_gnt_any & w_wr_free;
    assign w_last      = (int'(r_hold_cnt) == HOLD_CYCLES - 1);
    assign w_ptr_next  = (int'(w_gnt_idx) == NCH - 1) ? '0 : w_gnt_idx + c_PTR_W'(1);

    // Round-robin search starting at the pointer; first requester wins
    always_comb begin
        w_gnt_any  = 1'b0;
        w_gnt_idx  = '0;
        w_gnt_stop = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            for (int j = 0; j < NCH; j++) begin
                if (!w_gnt_any && w_req[j] && (j == (int'(r_ptr) + i) % NCH)) begin
                    w_gnt_any  = 1'b1;
                    w_gnt_idx  = c_PTR_W'(j);
                    w_gnt_stop = w_is_stop[j];
                end
            end
        end
    end

    // Per-channel grant and completion strobes
    always_comb begin
        w_grant = '0;
        w_done  = '0;
        for (int j = 0; j < NCH; j++) begin
            w_grant[j] = w_gnt_valid && (w_gnt_idx == c_PTR_W'(j));
            w_done[j]  = (r_wstate == WR_WRITE) && w_last && (r_owner == c_PTR_W'(j));
        end
    end

    // Shared writer: WRITE for HOLD_CYCLES, one GAP cycle, then free
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wstate   <= WR_IDLE;
            r_hold_cnt <= '0;
            r_ptr      <= '0;
            r_owner    <= '0;
            r_wr       <= 1'b0;
            r_inistop  <= CMD_NONE;
            r_dir      <= 8'h00;
        end else begin
            case (r_wstate)
                WR_WRITE: begin
                    if (w_last) begin
                        r_wstate  <= WR_GAP;
                        r_wr      <= 1'b0;
                        r_inistop <= CMD_NONE;
                        r_dir     <= 8'h00;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + c_HCNT_W'(1);
                    end
                end
                default: begin
                    if (w_gnt_valid) begin
                        r_wstate   <= WR_WRITE;
                        r_hold_cnt <= '0;
                        r_owner    <= w_gnt_idx;
                        r_ptr      <= w_ptr_next;
                        r_wr       <= 1'b1;
                        r_inistop  <= w_gnt_stop ? CMD_STOP : CMD_START;
                        r_dir      <= chan_dir(DIR_BASE, int'(w_gnt_idx));
                    end else begin
                        r_wstate  <= WR_IDLE;
                        r_wr      <= 1'b0;
                        r_inistop <= CMD_NONE;
                        r_dir     <= 8'h00;
                    end
                end
            endcase
        end
    end

    assign bus.WR_inistop = r_wr;
    assign bus.inistop    = r_inistop;
    assign bus.dir        = r_dir;
    assign bus.ring       = w_ring;
    assign bus.busy       = w_busy;

endmodule
`default_nettype wire
